// File: rtl/modbus_reg_arbiter_pkg.sv
// modbus_pkg: shared types and constants for the Modbus register port-B arbiter
package modbus_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;
    typedef struct packed {
        logic rd;
        logic id;
        logic err;
    } tag_t;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    localparam int DEF_A_WIDTH = 8;
    localparam int DEF_D_WIDTH = 16;
    localparam logic [7:0] EXC_ILLEGAL_ADDR = 8'h02;
endpackage

// File: rtl/modbus_reg_arbiter_if.sv
// modbus_reg_arbiter_if: two requester ports, shared read data and DPRAM port B
// slave modport is the arbiter side, master modport is the requesters/RAM side
interface modbus_reg_arbiter_if import modbus_pkg::*; #(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
);
    logic               m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [A_WIDTH-1:0] m0_addr;
    logic [D_WIDTH-1:0] m0_wdata;
    logic               m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [A_WIDTH-1:0] m1_addr;
    logic [D_WIDTH-1:0] m1_wdata;
    logic [D_WIDTH-1:0] rd_data;
    logic               ram_en, ram_we;
    logic [A_WIDTH-1:0] ram_addr;
    logic [D_WIDTH-1:0] ram_din, ram_dout;
    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata, ram_dout,
        output m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
        output rd_data, ram_en, ram_we, ram_addr, ram_din
    );
    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata, ram_dout,
        input  m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
        input  rd_data, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/modbus_reg_arbiter_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage shift register carrying {rd, id, err} per accepted beat
// ports: clk_in, rst_in, tag_in (accept cycle), tag_out (DEPTH cycles later)
module arb_tag_pipe import modbus_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];
    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= rst_in ? '0 : pipe_d[i];
    end
    assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/modbus_reg_arbiter.sv
// modbus_reg_arbiter: round-robin, burst-locking arbiter for DPRAM port B (m0 reader, m1 writer)
// ports: clk_in, rst_in (sync, active-high), bus (modbus_reg_arbiter_if.slave)
// optional MODBUS_ARB_ADDR_CHECK_EN: beats with addr >= REG_COUNT skip the RAM and pulse mX_err
module modbus_reg_arbiter import modbus_pkg::*; #(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16,
    parameter int REG_COUNT = 256
) (
    input logic clk_in,
    input logic rst_in,
    modbus_reg_arbiter_if.slave bus
);
`ifdef MODBUS_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int CW = $clog2(MAX_BURST + 1);
    owner_e             owner_q, owner_d;
    logic               last_q, last_d, en_q, en_d, we_q, we_d;
    logic [CW-1:0]      cnt_q, cnt_d, nxt;
    logic [A_WIDTH-1:0] addr_q, addr_d, addr;
    logic [D_WIDTH-1:0] din_q, din_d, wdata;
    logic               gnt0, gnt1, acc, sel, lock, we, bad;
    tag_t               tag_in, tag_out;
    always_comb begin
        // owner keeps exclusive access even while idle; in IDLE a tie goes to the master not served last
        gnt0 = !rst_in && bus.m0_req && (owner_q == OWN0 || (owner_q == IDLE && (!bus.m1_req || last_q == M1)));
        gnt1 = !rst_in && bus.m1_req && (owner_q == OWN1 || (owner_q == IDLE && !gnt0));
        acc = gnt0 || gnt1;
        sel = gnt1 ? M1 : M0;
        lock = sel ? bus.m1_lock : bus.m0_lock;
        we = sel ? bus.m1_we : bus.m0_we;
        addr = sel ? bus.m1_addr : bus.m0_addr;
        wdata = sel ? bus.m1_wdata : bus.m0_wdata;
        bad = CHECK_EN && (32'(addr) >= REG_COUNT);
        nxt = cnt_q + CW'(1);
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = cnt_q;
        en_d = 1'b0;
        we_d = 1'b0;
        addr_d = addr_q;
        din_d = din_q;
        tag_in = '{rd: acc && !we, id: sel, err: acc && bad};
        if (acc) begin
            en_d = !bad;
            we_d = we && !bad;
            addr_d = addr;
            din_d = wdata;
            last_d = sel;
            cnt_d = (!lock || 32'(nxt) >= MAX_BURST) ? '0 : nxt;
            if (!lock || 32'(nxt) >= MAX_BURST) owner_d = IDLE;
            else if (sel) owner_d = OWN1;
            else owner_d = OWN0;
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner_q <= IDLE;
            last_q <= M1;
            cnt_q <= '0;
            en_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            din_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            en_q <= en_d;
            we_q <= we_d;
            addr_q <= addr_d;
            din_q <= din_d;
        end
    end
    arb_tag_pipe #(.DEPTH(1 + RD_LAT)) u_tag (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tag_in(tag_in),
        .tag_out(tag_out)
    );
    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;
    assign bus.m0_rvalid = tag_out.rd && tag_out.id == M0;
    assign bus.m1_rvalid = tag_out.rd && tag_out.id == M1;
    assign bus.m0_err = tag_out.err && tag_out.id == M0;
    assign bus.m1_err = tag_out.err && tag_out.id == M1;
    assign bus.rd_data = tag_out.err ? '0 : bus.ram_dout;
    assign bus.ram_en = en_q;
    assign bus.ram_we = we_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din = din_q;
endmodule
